// File: rtl/time_field_pkg.sv
// time_field_pkg: shared definitions for the clock/date time-field counters.
//   - repeat FSM state encoding (IDLE, DELAY, REPEAT)
//   - default modulo constants for seconds, minutes and hours
//   - default auto-repeat timings (cycles of clk)
//   - cnt_width(): width of the auto-repeat down-stream cycle counter
package time_field_pkg;

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_DELAY  = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;

  // Counter must reach max(delay, period) - 1; never narrower than one bit.
  function automatic int cnt_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: button edge detection, direction arbitration and auto-repeat.
// Produces registered one-cycle step_up_o / step_dn_o pulses while enable_i
// (field in adjust mode) is high.
// Build option: TIME_FIELD_AUTOREPEAT_EN -- when defined, the repeat FSM and
// its counter are built; otherwise only edge detection remains and every
// press yields exactly one step.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable_i                 field currently addressed by the adjust selector
//   inc_i, dec_i             debounced button levels
//   step_up_o, step_dn_o     one-cycle step requests to the value register
//
// state      | meaning
// RPT_IDLE   | no button held; waiting for a single-button press edge
// RPT_DELAY  | press step issued; counting the initial hold delay
// RPT_REPEAT | repeating a step every REPEAT_PERIOD cycles while held
module btn_repeat
  import time_field_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic step_up_o,
  output logic step_dn_o
);

  logic inc_q, dec_q;
  logic arm_q;
  logic step_up_q, step_up_d;
  logic step_dn_q, step_dn_d;
  logic up_hold, dn_hold;
  logic up_edge, dn_edge;

  assign up_hold = inc_i & ~dec_i;
  assign dn_hold = dec_i & ~inc_i;
  // arm_q blocks a button that was already held through reset from looking
  // like a fresh press; it sets once both buttons have been seen released.
  assign up_edge = arm_q & up_hold & ~inc_q;
  assign dn_edge = arm_q & dn_hold & ~dec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      arm_q     <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      inc_q     <= inc_i;
      dec_q     <= dec_i;
      arm_q     <= arm_q | (~inc_i & ~dec_i);
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
    end
  end

  assign step_up_o = step_up_q;
  assign step_dn_o = step_dn_q;

`ifdef TIME_FIELD_AUTOREPEAT_EN
  localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             still_held;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_up_d   = dir_up_q;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    // Any change of direction, release or both-pressed ends the hold.
    still_held = dir_up_q ? up_hold : dn_hold;
    if (!enable_i) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          cnt_d = '0;
          if (up_edge || dn_edge) begin
            step_up_d = up_edge;
            step_dn_d = dn_edge;
            dir_up_d  = up_edge;
            state_d   = RPT_DELAY;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (!still_held) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == RPT_DELAY) ? DELAY_TC : PERIOD_TC)) begin
            step_up_d = dir_up_q;
            step_dn_d = ~dir_up_q;
            cnt_d     = '0;
            state_d   = RPT_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RPT_IDLE;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end
`else
  // Repeat timings have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  always_comb begin
    step_up_d = enable_i & up_edge;
    step_dn_d = enable_i & dn_edge;
  end
`endif

endmodule

// File: rtl/time_field_counter.sv
// time_field_counter: one field (seconds, minutes, hours, ...) of the
// clock/date datapath. Counts cascaded ticks modulo MODULO with a carry out
// in run mode; steps up/down from the buttons (with optional auto-repeat)
// in adjust mode; accepts a clamped synchronous load from RTC readback.
// Build option: TIME_FIELD_AUTOREPEAT_EN (see btn_repeat).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sel_i           adjust selector; adjust mode when sel_i == FIELD_ID
//   inc_i, dec_i    debounced button levels
//   tick_i          one-cycle count-up pulse (lower carry or 1 Hz strobe)
//   load_i          one-cycle load strobe, load_val_i clamped to MODULO-1
//   value_o         registered count
//   carry_o         one-cycle pulse as a tick wraps MODULO-1 to 0
//   adj_active_o    registered adjust-mode flag
module time_field_counter
  import time_field_pkg::*;
#(
  parameter int WIDTH         = 6,
  parameter int MODULO        = SEC_MOD,
  parameter int WRAP          = 1,
  parameter int SEL_W         = 2,
  parameter int FIELD_ID      = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o,
  output logic             adj_active_o
);

  localparam int               XW      = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH still compares correctly.
  localparam logic [XW-1:0]    MOD_EXT = XW'(MODULO);

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             adj_active_q;
  logic             adj_mode;
  logic             step_up, step_dn;

  assign adj_mode = (sel_i == SEL_W'(FIELD_ID));

  btn_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn_repeat (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (adj_mode),
    .inc_i     (inc_i),
    .dec_i     (dec_i),
    .step_up_o (step_up),
    .step_dn_o (step_dn)
  );

  // Step pulses are registered, so a selector change in the cycle a pulse
  // arrives must still suppress it: gate with the current adj_mode.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (load_i) begin
      value_d = ({1'b0, load_val_i} < MOD_EXT) ? load_val_i : MAX_VAL;
    end else if (adj_mode && step_up) begin
      if (value_q == MAX_VAL) value_d = (WRAP != 0) ? '0 : MAX_VAL;
      else                    value_d = value_q + WIDTH'(1);
    end else if (adj_mode && step_dn) begin
      if (value_q == '0) value_d = (WRAP != 0) ? MAX_VAL : '0;
      else               value_d = value_q - WIDTH'(1);
    end else if (!adj_mode && tick_i) begin
      if (value_q == MAX_VAL) begin
        value_d = '0;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q      <= '0;
      carry_q      <= 1'b0;
      adj_active_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      carry_q      <= carry_d;
      adj_active_q <= adj_mode;
    end
  end

  assign value_o      = value_q;
  assign carry_o      = carry_q;
  assign adj_active_o = adj_active_q;

endmodule

// File: doc/time_field_counter.md
# time_field_counter

Parametrised time-field counter for the clock/date datapath: one instance each for seconds, minutes, hours, day, and so on. In run mode it counts cascaded tick pulses modulo `MODULO` and emits carry. In adjust mode, when the adjust selector addresses this field, it steps up or down on button presses, with auto-repeat while a button is held. A sync load path lets the RTC readback overwrite the value.

## Interface
- `WIDTH`, default 6: counter width; must satisfy `MODULO <= 2**WIDTH`.
- `MODULO`, default 60: count range `0..MODULO-1`.
- `WRAP`, default 1: adjust-mode behaviour at the range ends. 1 = wrap; 0 = saturate at 0 and `MODULO-1`.
- `SEL_W`, default 2: adjust-selector width.
- `FIELD_ID`, default 1: selector value that addresses this field.
- `REPEAT_DELAY`, default 50_000_000: hold cycles before the first auto-repeat step.
- `REPEAT_PERIOD`, default 10_000_000: cycles between auto-repeat steps.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `sel` in `SEL_W`: adjust selector; field is in adjust mode when `sel == FIELD_ID`.
- `inc` in 1: level, debounced increment button.
- `dec` in 1: level, debounced decrement button.
- `tick` in 1: one-cycle count-up pulse, from the lower field's carry or the 1 Hz strobe.
- `load` in 1: one-cycle load strobe.
- `load_val` in `WIDTH`: value to load.
- `value` out `WIDTH`: current count, registered.
- `carry` out 1: one-cycle pulse when a tick wraps `MODULO-1` to 0.
- `adj_active` out 1: registered `sel == FIELD_ID`.

## Operation
- Reset: `value`=0, `carry`=0, `adj_active`=0, repeat FSM=IDLE, repeat counter=0, button edge registers=0.
- Priority per cycle, highest first: `rst`, `load`, adjust step, `tick`.
- `load`: `value` <= `load_val` if `load_val < MODULO`, else `MODULO-1`. No carry.
- Run mode (`sel != FIELD_ID`):
  - `tick`=1: `value`+1.
  - At `MODULO-1` a tick gives 0 and `carry`=1 for one cycle.
  - `inc`/`dec` ignored; repeat FSM held in IDLE.
- Adjust mode (`sel == FIELD_ID`):
  - `tick` ignored; `carry` held 0.
  - A step request is a rising edge of exactly one of `inc`/`dec`, or an auto-repeat pulse.
  - Up step: `value`+1. At `MODULO-1` it goes to 0 if `WRAP`=1, otherwise holds.
  - Down step: `value`-1. At 0 it goes to `MODULO-1` if `WRAP`=1, otherwise holds at 0.
  - `inc` and `dec` both high: no step; FSM goes to IDLE.
- Repeat FSM, with `btn` = exactly one of `inc`/`dec` held:
  - IDLE: on a press edge, issue one step, clear the counter, go to DELAY.
  - DELAY: count cycles. On reaching `REPEAT_DELAY-1`, issue a step, clear the counter, go to REPEAT.
  - REPEAT: on the counter reaching `REPEAT_PERIOD-1`, issue a step and clear the counter.
  - Release, both buttons, a direction change, or leaving adjust mode: go to IDLE and clear the counter.
  - The repeat counter is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))` bits.
- `sel` changing mid-hold: no step that cycle; FSM returns to IDLE. A new press edge is required.
- `value` is never `>= MODULO` after any cycle.

## Timing
- Button press sampled high at edge N (previous sample low): `value` changes at edge N+1.
- First repeat step: `REPEAT_DELAY` cycles after the press step. Subsequent steps: every `REPEAT_PERIOD` cycles.
- `tick` at edge N: `value` and `carry` update at N+1. `carry` is high for exactly one cycle, aligned with `value` becoming 0.
- `load` at edge N: `value` valid at N+1.
- `adj_active` lags `sel` by one cycle.
- `rst` mid-hold or mid-repeat: all state to reset values at the next edge. A still-held button needs a new rising edge to step.

## Configuration
- `TIME_FIELD_AUTOREPEAT_EN` defined: repeat FSM and counter are compiled in, behaving as above.
- `TIME_FIELD_AUTOREPEAT_EN` undefined: FSM and counter are removed. Exactly one step per rising edge; holding a button produces no further steps. `REPEAT_*` parameters are unused.

## Structure
- Shared package `time_field_pkg`:
  - repeat FSM state encoding (IDLE, DELAY, REPEAT);
  - default `MODULO` constants (`SEC_MOD`=60, `MIN_MOD`=60, `HOUR_MOD`=24);
  - default repeat timings.
- One sub-module, `btn_repeat`:
  - does edge detection, direction arbitration and the repeat FSM;
  - outputs one-cycle `step_up` / `step_dn` pulses;
  - takes `enable` = adjust mode;
  - contains only edge detection when `TIME_FIELD_AUTOREPEAT_EN` is undefined.
- Top module holds `value`, saturate/wrap arithmetic, the load clamp and carry.

## Test plan
- `MODULO`=60, run mode, `value`=59, one `tick` -> `value`=0 and `carry`=1 for exactly one cycle.
- Adjust mode, `WRAP`=1, `value`=0, `dec` press -> `value`=59. With `WRAP`=0 the same press -> stays 0.
- `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4, `inc` held 20 cycles from `value`=10 -> steps at cycles 1, 9, 13, 17; `value`=14. With the macro undefined -> `value`=11.
- `inc` and `dec` asserted together, and `tick` during adjust mode -> `value` unchanged, `carry`=0.
- `load` with `load_val`=63 and `MODULO`=60 -> `value`=59. `load` and `inc` edge in the same cycle -> load wins.
- `rst` asserted during REPEAT with `inc` still held -> `value`=0; no step until `inc` is released and re-pressed.
